btn_press_ctrl: RTL and testbench

BTN_PRESS_CTRL -- requirements
Module: btn_press_ctrl

---
 rtl/btn_press_pkg.sv | 33 +++
 rtl/btn_tick_gen.sv | 40 ++++
 rtl/btn_press_ctrl.sv | 148 ++++++++++++++
 tb/tb_btn_press_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_press_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_press_pkg
// Description : Shared state encoding, default parameter values and a
//               counter-width helper for the button press controller.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_press_pkg;

  // Per-channel press classifier states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_e;

  // Default parameter values for the controller
  localparam int c_DEF_N_BTN       = 4;
  localparam int c_DEF_COUNT_MAX   = 25000000;
  localparam int c_DEF_DEB_CYCLES  = 500000;
  localparam int c_DEF_HOLD_TICKS  = 10;
  localparam int c_DEF_ACTIVE_HIGH = 1;

  // Width of the hold-tick counter; HOLD_TICKS is capped at 255
  localparam int c_HOLD_W = 8;

  // Bits needed to hold values 0..max_val (never less than one bit)
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : btn_tick_gen
// Description : Free-running time base. Counts 0..COUNT_MAX-1 and raises
//               tick_o for the single cycle in which the count is at its top.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_tick_gen
  import btn_press_pkg::*;
#(
  parameter int COUNT_MAX = c_DEF_COUNT_MAX
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int                 c_CNT_W = cnt_width(COUNT_MAX - 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(COUNT_MAX - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_last;

  assign w_last = (r_cnt == c_LAST);

  // Wrapping period counter; the tick is decoded from its terminal value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick_o = w_last;

endmodule
`default_nettype wire

// File: rtl/btn_press_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : btn_press_ctrl
// Description : Multi-channel push-button front end. Each channel is
//               synchronised, polarity-normalised and debounced, then a
//               small FSM classifies presses as short (released before
//               HOLD_TICKS time-base ticks) or long (held that long).
// Revision    : 1.0 - initial release
// ============================================================================
module btn_press_ctrl
  import btn_press_pkg::*;
#(
  parameter int N_BTN       = c_DEF_N_BTN,
  parameter int COUNT_MAX   = c_DEF_COUNT_MAX,
  parameter int DEB_CYCLES  = c_DEF_DEB_CYCLES,
  parameter int HOLD_TICKS  = c_DEF_HOLD_TICKS,
  parameter int ACTIVE_HIGH = c_DEF_ACTIVE_HIGH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] short_o,
  output logic [N_BTN-1:0] long_o,
  output logic [N_BTN-1:0] held_o,
  output logic [N_BTN-1:0] pressed_o,
  output logic             tick_o
);

  // Raw pin level of a released button; synchronisers reset to it so that
  // leaving reset never looks like an edge.
  localparam logic c_REL_LVL = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

  localparam int                  c_DEB_W    = cnt_width(DEB_CYCLES - 1);
  localparam logic [c_DEB_W-1:0]  c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_TICKS - 1);

  logic w_tick;

  btn_tick_gen #(
    .COUNT_MAX (COUNT_MAX)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .tick_o (w_tick)
  );

  assign tick_o = w_tick;

  genvar i;
  generate
    for (i = 0; i < N_BTN; i++) begin : g_ch
      logic [1:0]          r_sync;
      logic                w_level;
      logic [c_DEB_W-1:0]  r_deb_cnt;
      logic                r_pressed;
      btn_state_e          r_state;
      btn_state_e          w_state_nxt;
      logic [c_HOLD_W-1:0] r_hold;
      logic [c_HOLD_W-1:0] w_hold_nxt;
      logic                w_short;
      logic                w_long;

      // Two-flop synchroniser for the asynchronous pin
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sync <= {2{c_REL_LVL}};
        end else begin
          r_sync <= {r_sync[0], btn_in[i]};
        end
      end

      // 1 means "pressed" regardless of pin polarity
      assign w_level = (ACTIVE_HIGH != 0) ? r_sync[1] : ~r_sync[1];

      // Debounce: accept a new level only after DEB_CYCLES consecutive
      // disagreeing samples; any agreeing sample restarts the count.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_deb_cnt <= '0;
          r_pressed <= 1'b0;
        end else if (w_level == r_pressed) begin
          r_deb_cnt <= '0;
        end else if (r_deb_cnt == c_DEB_LAST) begin
          r_deb_cnt <= '0;
          r_pressed <= w_level;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end

      // Press classifier state and hold-tick counter registers
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= IDLE;
          r_hold  <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_hold  <= w_hold_nxt;
        end
      end

      // Next state and pulses; a release is checked before the final tick
      // so that a coincident release is reported as a short press.
      always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_short     = 1'b0;
        w_long      = 1'b0;
        case (r_state)
          IDLE: begin
            if (r_pressed) begin
              w_state_nxt = PRESSED;
              w_hold_nxt  = '0;
            end
          end
          PRESSED: begin
            if (!r_pressed) begin
              w_state_nxt = IDLE;
              w_short     = 1'b1;
            end else if (w_tick) begin
              w_hold_nxt = r_hold + 1'b1;
              if (r_hold == c_HOLD_LAST) begin
                w_state_nxt = HELD;
                w_long      = 1'b1;
              end
            end
          end
          HELD: begin
            // Counter is frozen here, so it can never wrap.
            if (!r_pressed) begin
              w_state_nxt = IDLE;
            end
          end
          default: begin
            w_state_nxt = IDLE;
          end
        endcase
      end

      assign short_o[i]   = w_short;
      assign long_o[i]    = w_long;
      assign held_o[i]    = (r_state == HELD);
      assign pressed_o[i] = r_pressed;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_btn_press_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_press_ctrl
// Description : Self-checking bench for btn_press_ctrl. Two instances share
//               one stimulus (active-high pins and inverted active-low pins)
//               and are compared every cycle against a cycle-indexed
//               behavioural model, plus directed scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_press_ctrl;

  localparam int NB  = 2;
  localparam int CM  = 4;
  localparam int DEB = 3;
  localparam int HT  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn = '0;
  logic [NB-1:0] btn_n;
  logic [NB-1:0] sh_a, lg_a, hd_a, pr_a;
  logic [NB-1:0] sh_l, lg_l, hd_l, pr_l;
  logic          tk_a, tk_l;

  assign btn_n = ~btn;

  always #5 clk = ~clk;

  btn_press_ctrl #(
    .N_BTN(NB), .COUNT_MAX(CM), .DEB_CYCLES(DEB), .HOLD_TICKS(HT), .ACTIVE_HIGH(1)
  ) dut_ah (
    .clk(clk), .rst(rst), .btn_in(btn),
    .short_o(sh_a), .long_o(lg_a), .held_o(hd_a), .pressed_o(pr_a), .tick_o(tk_a)
  );

  btn_press_ctrl #(
    .N_BTN(NB), .COUNT_MAX(CM), .DEB_CYCLES(DEB), .HOLD_TICKS(HT), .ACTIVE_HIGH(0)
  ) dut_al (
    .clk(clk), .rst(rst), .btn_in(btn_n),
    .short_o(sh_l), .long_o(lg_l), .held_o(hd_l), .pressed_o(pr_l), .tick_o(tk_l)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  // cyc = cycles since reset release; raw_q[c] = press level driven in cycle c
  int            cyc;
  logic [NB-1:0] raw_q[$];
  logic [NB-1:0] m_pressed;
  bit            m_active[NB];   // a press was registered in an earlier cycle
  bit            m_long[NB];     // that press already qualified as long
  int            m_ticks[NB];    // ticks seen since the press was registered
  logic [NB-1:0] e_short, e_long, e_held;
  logic          e_tick;

  // ---------------- scenario statistics (from DUT) ----------------
  int            n_short[NB], n_long[NB], n_pr_hi[NB];
  int            short_cyc[NB], long_cyc[NB], rise_cyc[NB], held_last[NB];
  logic [NB-1:0] prev_pr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic raw_at(input int c, input int ch);
    logic [NB-1:0] v;
    if (c < 0) return 1'b0;
    v = raw_q[c];
    return v[ch];
  endfunction

  task automatic model_reset();
    cyc = 0;
    raw_q.delete();
    m_pressed = '0;
    for (int ch = 0; ch < NB; ch++) begin
      m_active[ch] = 1'b0;
      m_long[ch]   = 1'b0;
      m_ticks[ch]  = 0;
    end
  endtask

  task automatic clear_stats();
    for (int ch = 0; ch < NB; ch++) begin
      n_short[ch] = 0; n_long[ch] = 0; n_pr_hi[ch] = 0;
      short_cyc[ch] = -1; long_cyc[ch] = -1; rise_cyc[ch] = -1; held_last[ch] = -1;
    end
  endtask

  // Expected outputs for the current cycle from the press-record rules
  task automatic model_outputs();
    e_tick  = ((cyc % CM) == CM - 1);
    e_short = '0;
    e_long  = '0;
    e_held  = '0;
    for (int ch = 0; ch < NB; ch++) begin
      if (m_active[ch]) begin
        if (m_long[ch]) begin
          e_held[ch] = 1'b1;
          if (!m_pressed[ch]) m_active[ch] = 1'b0;
        end else if (!m_pressed[ch]) begin
          e_short[ch]  = 1'b1;
          m_active[ch] = 1'b0;
        end else if (e_tick) begin
          m_ticks[ch]++;
          if (m_ticks[ch] == HT) begin
            e_long[ch] = 1'b1;
            m_long[ch] = 1'b1;
          end
        end
      end else if (m_pressed[ch]) begin
        m_active[ch] = 1'b1;
        m_ticks[ch]  = 0;
        m_long[ch]   = 1'b0;
      end
    end
  endtask

  // Debounced level for the next cycle: flips once the DEB most recent
  // synchronised samples (input delayed by two cycles) all disagree.
  task automatic model_advance();
    for (int ch = 0; ch < NB; ch++) begin
      bit all_diff = 1'b1;
      for (int k = 0; k < DEB; k++)
        if (raw_at(cyc - 2 - k, ch) == m_pressed[ch]) all_diff = 1'b0;
      if (all_diff) m_pressed[ch] = ~m_pressed[ch];
    end
    cyc++;
  endtask

  // Called at a falling edge: check this cycle, then drive the next input.
  task automatic step(input logic [NB-1:0] b);
    model_outputs();
    chk("pressed_ah", pr_a, m_pressed);
    chk("short_ah",   sh_a, e_short);
    chk("long_ah",    lg_a, e_long);
    chk("held_ah",    hd_a, e_held);
    chk("tick_ah",    tk_a, e_tick);
    chk("pressed_al", pr_l, m_pressed);
    chk("short_al",   sh_l, e_short);
    chk("long_al",    lg_l, e_long);
    chk("held_al",    hd_l, e_held);
    chk("tick_al",    tk_l, e_tick);
    for (int ch = 0; ch < NB; ch++) begin
      if (sh_a[ch]) begin n_short[ch]++; short_cyc[ch] = cyc; end
      if (lg_a[ch]) begin n_long[ch]++;  long_cyc[ch]  = cyc; end
      if (hd_a[ch]) held_last[ch] = cyc;
      if (pr_a[ch]) n_pr_hi[ch]++;
      if (pr_a[ch] && !prev_pr[ch] && rise_cyc[ch] < 0) rise_cyc[ch] = cyc;
    end
    prev_pr = pr_a;
    btn = b;
    raw_q.push_back(b);
    model_advance();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ah"}, {sh_a, lg_a, hd_a, pr_a, tk_a}, '0);
    chk({tag, "_al"}, {sh_l, lg_l, hd_l, pr_l, tk_l}, '0);
  endtask

  int s, r, t1, tt, lat;

  initial begin
    model_reset();
    clear_stats();
    prev_pr = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (6) step('0);

    // Short press on channel 0
    clear_stats(); s = cyc;
    repeat (10) step(2'b01);
    repeat (14) step(2'b00);
    chk("s1_press_lat", rise_cyc[0] - s, 5);
    chk("s1_short_cnt", n_short[0], 1);
    chk("s1_short_cyc", short_cyc[0], s + 15);
    chk("s1_long_cnt",  n_long[0], 0);

    // Long press on channel 1
    clear_stats(); s = cyc;
    repeat (40) step(2'b10);
    repeat (15) step(2'b00);
    lat = long_cyc[1] - rise_cyc[1];
    chk("s2_long_cnt",  n_long[1], 1);
    chk("s2_long_lat",  (lat >= (HT - 1) * CM + 1) && (lat <= HT * CM), 1);
    chk("s2_short_cnt", n_short[1], 0);
    chk("s2_held_end",  held_last[1], s + 45);

    // Chatter shorter than the debounce window
    clear_stats();
    for (int i = 0; i < 30; i++) step({1'b0, ((i / 2) % 2) == 0});
    repeat (10) step(2'b00);
    chk("s3_pressed_hi", n_pr_hi[0], 0);
    chk("s3_pulses",     n_short[0] + n_long[0], 0);

    // Both channels pressed together
    clear_stats(); s = cyc;
    repeat (8) step(2'b11);
    repeat (14) step(2'b00);
    chk("s4_short_cyc0", short_cyc[0], s + 13);
    chk("s4_short_cyc1", short_cyc[1], s + 13);
    chk("s4_long_cnt",   n_long[0] + n_long[1], 0);

    // Release landing on the qualifying tick: release wins
    clear_stats(); s = cyc;
    r  = s + 5;
    t1 = r + 1;
    while ((t1 % CM) != CM - 1) t1++;
    tt = t1 + (HT - 1) * CM;
    while (cyc < tt - 5) step(2'b01);
    repeat (15) step(2'b00);
    chk("s5_short_cyc", short_cyc[0], tt);
    chk("s5_short_cnt", n_short[0], 1);
    chk("s5_long_cnt",  n_long[0], 0);

    // Reset in the middle of a press
    clear_stats();
    repeat (10) step(2'b10);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_stats();
    prev_pr = '0;
    repeat (12) step(2'b10);
    chk("s6_repress_lat", rise_cyc[1], 5);
    chk("s6_pulses",      n_short[1] + n_long[1], 0);
    repeat (12) step(2'b00);
    chk("s6_new_short",   n_short[1], 1);

    // Random segments checked cycle by cycle against the model
    for (int seg = 0; seg < 30; seg++) begin
      logic [NB-1:0] b;
      int len;
      b   = NB'($urandom_range(0, 3));
      len = $urandom_range(1, 28);
      repeat (len) step(b);
    end
    repeat (30) step(2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
